// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state type and button indices for the count run controller
package count_ctrl_pkg;
  typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;
  localparam int BTN_RUN   = 0;
  localparam int BTN_STEP  = 1;
  localparam int BTN_CLEAR = 2;
  localparam int NUM_BTN   = 3;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchronizer plus edge detect, emitting a registered one-cycle event per rising edge
module btn_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_event
);
  logic [2:0] sync;
  // sync[1:0] resynchronize the raw level, sync[2] holds the previous level for rise detection
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync    <= '0;
      o_event <= 1'b0;
    end else begin
      sync    <= {sync[1:0], i_raw};
      o_event <= sync[1] & ~sync[2];
    end
  end
endmodule

// File: rtl/count_run_controller.sv
// count_run_controller: run/stop/step/clear sequencer with selectable direction and wrap-or-stop limits
module count_run_controller
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_COUNT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_btn_run,
  input  logic             i_btn_step,
  input  logic             i_btn_clear,
  input  logic             i_dir,
  input  logic             i_wrap_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_running,
  output logic             o_limit_pulse
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  if (MAX_COUNT < 1 || longint'(MAX_COUNT) > (longint'(1) << WIDTH) - 1) begin : g_bad_max
    $error("MAX_COUNT out of range 1 .. 2**WIDTH-1");
  end

  logic [NUM_BTN-1:0] raw, ev;
  assign raw[BTN_RUN]   = i_btn_run;
  assign raw[BTN_STEP]  = i_btn_step;
  assign raw[BTN_CLEAR] = i_btn_clear;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_edge_sync u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_raw   (raw[b]),
      .o_event (ev[b])
    );
  end

  state_t           state, state_nx;
  logic             adv, at_lim, hit;
  logic [WIDTH-1:0] count_nx;

  // advance is qualified by the pre-toggle state; clear wins over any advance
  always_comb begin
    adv      = (state == RUNNING) ? i_tick : ev[BTN_STEP];
    at_lim   = i_dir ? (o_count == MAXV) : (o_count == '0);
    hit      = ~ev[BTN_CLEAR] & adv & at_lim;
    count_nx = ev[BTN_CLEAR] ? '0 :
               !adv          ? o_count :
               !at_lim       ? (i_dir ? o_count + 1'b1 : o_count - 1'b1) :
               !i_wrap_en    ? o_count :
               i_dir         ? '0 : MAXV;
    state_nx = (hit & ~i_wrap_en) ? STOPPED :
               ev[BTN_RUN]        ? ((state == RUNNING) ? STOPPED : RUNNING) :
               state;
  end

  // registered state, count and limit pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= STOPPED;
      o_count       <= '0;
      o_running     <= 1'b0;
      o_limit_pulse <= 1'b0;
    end else begin
      state         <= state_nx;
      o_count       <= count_nx;
      o_running     <= (state_nx == RUNNING);
      o_limit_pulse <= hit;
    end
  end
endmodule

// File: tb/tb_count_run_controller.sv
// tb_count_run_controller: table, directed corner sequences and random stimulus against a behavioural model
module tb_count_run_controller;
  localparam int MAXC = 99;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       tick = 1'b0, btn_run = 1'b0, btn_step = 1'b0, btn_clr = 1'b0;
  logic       dir = 1'b1, wrap = 1'b1;
  logic [7:0] o_count;
  logic       o_running, o_limit_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  int     m_cnt;
  bit     m_run, m_lim;
  bit [3:0] h [3];

  typedef struct {
    int tick, run, step, clr, dir, wrap, cnt, running, lim;
  } vec_t;
  vec_t tbl [32];

  always #5 i_clk = ~i_clk;

  count_run_controller #(.WIDTH(8), .MAX_COUNT(MAXC)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_tick        (tick),
    .i_btn_run     (btn_run),
    .i_btn_step    (btn_step),
    .i_btn_clear   (btn_clr),
    .i_dir         (dir),
    .i_wrap_en     (wrap),
    .o_count       (o_count),
    .o_running     (o_running),
    .o_limit_pulse (o_limit_pulse)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_run = 0;
    m_lim = 0;
    for (int b = 0; b < 3; b++) h[b] = '0;
  endtask

  // one clock edge: model sees the same inputs the DUT samples, then outputs are compared
  task automatic edge_chk();
    bit ev [3];
    bit raw [3];
    bit adv, stop;
    @(posedge i_clk);
    raw[0] = btn_run;
    raw[1] = btn_step;
    raw[2] = btn_clr;
    for (int b = 0; b < 3; b++) begin
      ev[b] = h[b][2] & ~h[b][3];
      h[b]  = {h[b][2:0], raw[b]};
    end
    m_lim = 0;
    stop  = 0;
    adv   = m_run ? tick : ev[1];
    if (ev[2]) m_cnt = 0;
    else if (adv) begin
      if ((dir && m_cnt == MAXC) || (!dir && m_cnt == 0)) begin
        m_lim = 1;
        if (wrap) m_cnt = (m_cnt + (dir ? 1 : MAXC)) % (MAXC + 1);
        else stop = 1;
      end else m_cnt = dir ? m_cnt + 1 : m_cnt - 1;
    end
    m_run = stop ? 1'b0 : (ev[0] ? !m_run : m_run);
    #1;
    chk("model_count", o_count, m_cnt);
    chk("model_running", o_running, m_run);
    chk("model_limit", o_limit_pulse, m_lim);
  endtask

  task automatic press(input int b);
    if (b == 0) btn_run = 1'b1;
    else if (b == 1) btn_step = 1'b1;
    else btn_clr = 1'b1;
    edge_chk();
    btn_run = 1'b0;
    btn_step = 1'b0;
    btn_clr = 1'b0;
    repeat (3) edge_chk();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n_chg;
    logic [7:0] prev;
    tbl = '{
      '{0,1,0,0,1,1, 0,0,0}, '{0,1,0,0,1,1, 0,0,0}, '{0,0,0,0,1,1, 0,0,0}, '{0,0,0,0,1,1, 0,1,0},
      '{1,0,0,0,1,1, 1,1,0}, '{1,0,0,0,1,1, 2,1,0}, '{0,0,0,0,1,1, 2,1,0}, '{1,0,0,0,1,1, 3,1,0},
      '{1,0,0,0,1,1, 4,1,0}, '{1,0,0,0,1,1, 5,1,0}, '{0,0,1,0,1,1, 5,1,0}, '{0,0,0,0,1,1, 5,1,0},
      '{0,0,0,0,1,1, 5,1,0}, '{0,0,0,0,1,1, 5,1,0}, '{0,1,0,0,1,1, 5,1,0}, '{0,0,0,0,1,1, 5,1,0},
      '{0,0,0,0,1,1, 5,1,0}, '{0,0,0,0,1,1, 5,0,0}, '{1,0,0,0,1,1, 5,0,0}, '{0,0,1,0,0,1, 5,0,0},
      '{0,0,1,0,0,1, 5,0,0}, '{0,0,0,0,0,1, 5,0,0}, '{0,0,0,0,0,1, 4,0,0}, '{0,0,0,1,0,1, 4,0,0},
      '{0,0,0,0,0,1, 4,0,0}, '{0,0,0,0,0,1, 4,0,0}, '{0,0,0,0,0,1, 0,0,0}, '{0,0,1,0,0,0, 0,0,0},
      '{0,0,0,0,0,0, 0,0,0}, '{0,0,0,0,0,0, 0,0,0}, '{0,0,0,0,0,0, 0,0,1}, '{0,0,0,0,0,0, 0,0,0}
    };
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    chk("reset_count", o_count, 0);
    chk("reset_running", o_running, 0);
    chk("reset_limit", o_limit_pulse, 0);
    i_rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      tick     = tbl[i].tick[0];
      btn_run  = tbl[i].run[0];
      btn_step = tbl[i].step[0];
      btn_clr  = tbl[i].clr[0];
      dir      = tbl[i].dir[0];
      wrap     = tbl[i].wrap[0];
      edge_chk();
      chk($sformatf("tbl%0d_count", i), o_count, tbl[i].cnt);
      chk($sformatf("tbl%0d_running", i), o_running, tbl[i].running);
      chk($sformatf("tbl%0d_limit", i), o_limit_pulse, tbl[i].lim);
    end

    wrap = 1'b1;
    dir = 1'b0;
    press(1);
    chk("step_down_wrap_count", o_count, MAXC);
    chk("step_down_wrap_limit", o_limit_pulse, 1);
    press(1);
    chk("step_down_count", o_count, MAXC - 1);
    dir = 1'b1;
    press(0);
    chk("run_again", o_running, 1);
    tick = 1'b1;
    edge_chk();
    chk("up_to_max_count", o_count, MAXC);
    chk("up_to_max_limit", o_limit_pulse, 0);
    edge_chk();
    chk("wrap_count", o_count, 0);
    chk("wrap_limit", o_limit_pulse, 1);
    chk("wrap_running", o_running, 1);
    tick = 1'b0;
    edge_chk();
    chk("wrap_limit_one_cycle", o_limit_pulse, 0);

    tick = 1'b1;
    edge_chk();
    wrap = 1'b0;
    dir = 1'b0;
    edge_chk();
    chk("down_to_zero_count", o_count, 0);
    chk("down_to_zero_limit", o_limit_pulse, 0);
    edge_chk();
    chk("stop_hold_count", o_count, 0);
    chk("stop_limit", o_limit_pulse, 1);
    chk("stop_running", o_running, 0);
    tick = 1'b0;
    edge_chk();
    chk("stop_limit_one_cycle", o_limit_pulse, 0);

    dir = 1'b1;
    wrap = 1'b1;
    repeat (3) press(1);
    chk("steps_to_three", o_count, 3);
    btn_step = 1'b1;
    n_chg = 0;
    prev = o_count;
    for (int i = 0; i < 20; i++) begin
      tick = (i < 4);
      edge_chk();
      if (o_count != prev) n_chg++;
      prev = o_count;
    end
    tick = 1'b0;
    btn_step = 1'b0;
    edge_chk();
    chk("held_step_count", o_count, 4);
    chk("held_step_changes", n_chg, 1);
    press(0);
    chk("run_after_held", o_running, 1);
    press(1);
    chk("step_ignored_running", o_count, 4);

    tick = 1'b1;
    repeat (3) edge_chk();
    chk("reach_seven", o_count, 7);
    tick = 1'b0;
    btn_clr = 1'b1;
    edge_chk();
    btn_clr = 1'b0;
    repeat (2) edge_chk();
    tick = 1'b1;
    edge_chk();
    chk("clear_tick_count", o_count, 0);
    chk("clear_tick_running", o_running, 1);
    chk("clear_tick_limit", o_limit_pulse, 0);

    repeat (42) edge_chk();
    chk("reach_42", o_count, 42);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_count", o_count, 0);
    chk("async_rst_running", o_running, 0);
    chk("async_rst_limit", o_limit_pulse, 0);
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    edge_chk();
    chk("tick_after_rst_count", o_count, 0);
    chk("tick_after_rst_running", o_running, 0);
    tick = 1'b0;

    for (int i = 0; i < 400; i++) begin
      tick = ($urandom % 3) == 0;
      if ($urandom % 8 == 0) btn_run = ~btn_run;
      if ($urandom % 5 == 0) btn_step = ~btn_step;
      if ($urandom % 24 == 0) btn_clr = ~btn_clr;
      if ($urandom % 16 == 0) dir = ~dir;
      if ($urandom % 20 == 0) wrap = ~wrap;
      edge_chk();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
